// File: rtl/decode_stage_if.sv
// Fetch-to-decode and decode-to-execute handshake bundle.
// Master drives fetch/execute side; slave is the decode stage.
interface decode_stage_if #(
  parameter int INSTR_W = 32,
  parameter int DATA_W  = 16,
  parameter int REG_AW  = 5,
  parameter int MEM_AW  = 8,
  parameter int CNT_W   = 8
) ();
  logic               in_valid;
  logic               in_ready;
  logic [INSTR_W-1:0] in_instr;
  logic               flush;
  logic               out_valid;
  logic               out_ready;
  logic [5:0]         out_op;
  logic [REG_AW-1:0]  out_rd;
  logic [REG_AW-1:0]  out_rd_hi;
  logic [REG_AW-1:0]  out_rs1;
  logic [REG_AW-1:0]  out_rs2;
  logic               out_rs1_en;
  logic               out_rs2_en;
  logic [DATA_W-1:0]  out_imm;
  logic               out_use_imm;
  logic [MEM_AW-1:0]  out_mem_addr;
  logic               out_mem_rd;
  logic               out_mem_wr;
  logic               out_reg_we;
  logic               out_reg_we_hi;
  logic               out_illegal;
  logic [CNT_W-1:0]   illegal_count;

  modport master (
    output in_valid, in_instr, flush, out_ready,
    input  in_ready, out_valid, out_op, out_rd,
    input  out_rd_hi, out_rs1, out_rs2,
    input  out_rs1_en, out_rs2_en, out_imm,
    input  out_use_imm, out_mem_addr, out_mem_rd,
    input  out_mem_wr, out_reg_we, out_reg_we_hi,
    input  out_illegal, illegal_count
  );

  modport slave (
    input  in_valid, in_instr, flush, out_ready,
    output in_ready, out_valid, out_op, out_rd,
    output out_rd_hi, out_rs1, out_rs2,
    output out_rs1_en, out_rs2_en, out_imm,
    output out_use_imm, out_mem_addr, out_mem_rd,
    output out_mem_wr, out_reg_we, out_reg_we_hi,
    output out_illegal, illegal_count
  );
endinterface

// File: rtl/decode_stage.sv
// Registered decode stage: field split, control enables,
// valid/ready skid-free handshake, load-use interlock.
module decode_stage #(
  parameter int INSTR_W = 32,
  parameter int DATA_W  = 16,
  parameter int REG_AW  = 5,
  parameter int MEM_AW  = 8,
  parameter int CNT_W   = 8
) (
  input  logic         clk,
  input  logic         rst,
  decode_stage_if.slave bus
);

  typedef struct packed {
    logic [5:0]        op;
    logic [REG_AW-1:0] rd;
    logic [REG_AW-1:0] rd_hi;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic              rs1_en;
    logic              rs2_en;
    logic [DATA_W-1:0] imm;
    logic              use_imm;
    logic [MEM_AW-1:0] mem_addr;
    logic              mem_rd;
    logic              mem_wr;
    logic              reg_we;
    logic              reg_we_hi;
    logic              illegal;
  } dec_t;

  function automatic dec_t decode(
    input logic [INSTR_W-1:0] i
  );
    dec_t       d;
    logic [5:0] op;
    op       = i[31:26];
    d        = '0;
    d.op     = op;
    d.rd     = (op <= 6'd2) ? i[25:21] : i[20:16];
    d.rd_hi  = i[25:21];
    d.rs1    = i[4:0];
    d.rs2    = i[9:5];
    d.imm    = DATA_W'(i[15:0]);
    d.mem_addr = (op == 6'd3) ? i[18 +: MEM_AW]
                              : i[0 +: MEM_AW];
    unique case (1'b1)
      (op == 6'd0): begin
        d.use_imm = 1'b1;
        d.reg_we  = 1'b1;
      end
      (op == 6'd1),
      (op == 6'd6),
      (op == 6'd14): begin
        d.rs1_en = 1'b1;
        d.reg_we = 1'b1;
      end
      (op == 6'd2): begin
        d.mem_rd = 1'b1;
        d.reg_we = 1'b1;
      end
      (op == 6'd3): begin
        d.rs1_en = 1'b1;
        d.mem_wr = 1'b1;
      end
      (op == 6'd7): begin
        d.rs1_en    = 1'b1;
        d.rs2_en    = 1'b1;
        d.reg_we    = 1'b1;
        d.reg_we_hi = 1'b1;
      end
      (op == 6'd4), (op == 6'd5),
      (op == 6'd8), (op == 6'd9),
      (op == 6'd10), (op == 6'd11),
      (op == 6'd12), (op == 6'd13),
      (op == 6'd15), (op == 6'd16): begin
        d.rs1_en = 1'b1;
        d.rs2_en = 1'b1;
        d.reg_we = 1'b1;
      end
      default: d.illegal = 1'b1;
    endcase
    return d;
  endfunction

  dec_t              bun_q, bun_d;
  dec_t              in_dec;
  logic              valid_q, valid_d;
  logic              shadow_q, shadow_d;
  logic [REG_AW-1:0] shadow_rd_q, shadow_rd_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              hit1, hit2, hazard;
  logic              in_ready, in_xfer, out_xfer;

  // A register is "pending" if an unretired LOAD targets it
  // or a LOAD retired last cycle (data not yet forwardable).
  always_comb begin
    in_dec = decode(bus.in_instr);
    hit1 = (valid_q && bun_q.mem_rd
            && bun_q.rd == in_dec.rs1)
        || (shadow_q && shadow_rd_q == in_dec.rs1);
    hit2 = (valid_q && bun_q.mem_rd
            && bun_q.rd == in_dec.rs2)
        || (shadow_q && shadow_rd_q == in_dec.rs2);
    hazard = bus.in_valid
          && ((in_dec.rs1_en && hit1)
           || (in_dec.rs2_en && hit2));
    in_ready = !rst && !bus.flush && !hazard
            && (!valid_q || bus.out_ready);
    in_xfer  = bus.in_valid && in_ready;
    out_xfer = valid_q && bus.out_ready;
  end

  always_comb begin
    valid_d     = valid_q;
    bun_d       = bun_q;
    shadow_d    = 1'b0;
    shadow_rd_d = shadow_rd_q;
    cnt_d       = cnt_q;
    if (bus.flush) begin
      valid_d = 1'b0;
    end else begin
      if (out_xfer) begin
        valid_d     = 1'b0;
        shadow_d    = bun_q.mem_rd;
        shadow_rd_d = bun_q.rd;
      end
      if (in_xfer) begin
        valid_d = 1'b1;
        bun_d   = in_dec;
        if (in_dec.illegal && cnt_q != '1)
          cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q     <= 1'b0;
      bun_q       <= '0;
      shadow_q    <= 1'b0;
      shadow_rd_q <= '0;
      cnt_q       <= '0;
    end else begin
      valid_q     <= valid_d;
      bun_q       <= bun_d;
      shadow_q    <= shadow_d;
      shadow_rd_q <= shadow_rd_d;
      cnt_q       <= cnt_d;
    end
  end

  assign bus.in_ready      = in_ready;
  assign bus.out_valid     = valid_q;
  assign bus.out_op        = bun_q.op;
  assign bus.out_rd        = bun_q.rd;
  assign bus.out_rd_hi     = bun_q.rd_hi;
  assign bus.out_rs1       = bun_q.rs1;
  assign bus.out_rs2       = bun_q.rs2;
  assign bus.out_rs1_en    = bun_q.rs1_en;
  assign bus.out_rs2_en    = bun_q.rs2_en;
  assign bus.out_imm       = bun_q.imm;
  assign bus.out_use_imm   = bun_q.use_imm;
  assign bus.out_mem_addr  = bun_q.mem_addr;
  assign bus.out_mem_rd    = bun_q.mem_rd;
  assign bus.out_mem_wr    = bun_q.mem_wr;
  assign bus.out_reg_we    = bun_q.reg_we;
  assign bus.out_reg_we_hi = bun_q.reg_we_hi;
  assign bus.out_illegal   = bun_q.illegal;
  assign bus.illegal_count = cnt_q;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: reference decode model,
// handshake, interlock, saturation, flush and reset checks.
module tb_decode_stage;

  typedef struct packed {
    logic [5:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rd_hi;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        rs1_en;
    logic        rs2_en;
    logic [15:0] imm;
    logic        use_imm;
    logic [7:0]  mem_addr;
    logic        mem_rd;
    logic        mem_wr;
    logic        reg_we;
    logic        reg_we_hi;
    logic        illegal;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;
  int   exp_cnt = 0;
  bit   rnd = 1'b0;
  exp_t q[$];

  decode_stage_if bus ();

  decode_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  localparam logic [31:0] LDI  = 32'h0040_1234;
  localparam logic [31:0] ADD  = 32'h1003_0022;
  localparam logic [31:0] LD5  = 32'h08A0_0020;
  localparam logic [31:0] ADD5 = 32'h1003_0025;
  localparam logic [31:0] ADDB = 32'h1003_00A1;
  localparam logic [31:0] MUL  = 32'h1CE4_0022;
  localparam logic [31:0] STR  = 32'h0D68_0003;
  localparam logic [31:0] MOV  = 32'h0520_0003;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [31:0] i);
    exp_t e;
    e = '0;
    e.op = i[31:26];
    e.rd = (i[31:26] < 3) ? i[25:21] : i[20:16];
    e.rd_hi = i[25:21];
    e.rs1 = i[4:0];
    e.rs2 = i[9:5];
    e.imm = i[15:0];
    e.mem_addr = (i[31:26] == 3) ? i[25:18] : i[7:0];
    case (i[31:26])
      0: begin e.use_imm = 1; e.reg_we = 1; end
      1, 6, 14: begin e.rs1_en = 1; e.reg_we = 1; end
      2: begin e.mem_rd = 1; e.reg_we = 1; end
      3: begin e.rs1_en = 1; e.mem_wr = 1; end
      7: begin
        e.rs1_en = 1; e.rs2_en = 1;
        e.reg_we = 1; e.reg_we_hi = 1;
      end
      4, 5, 8, 9, 10, 11, 12, 13, 15, 16: begin
        e.rs1_en = 1; e.rs2_en = 1; e.reg_we = 1;
      end
      default: e.illegal = 1;
    endcase
    return e;
  endfunction

  function automatic exp_t got_bun();
    return {bus.out_op, bus.out_rd, bus.out_rd_hi,
            bus.out_rs1, bus.out_rs2, bus.out_rs1_en,
            bus.out_rs2_en, bus.out_imm, bus.out_use_imm,
            bus.out_mem_addr, bus.out_mem_rd,
            bus.out_mem_wr, bus.out_reg_we,
            bus.out_reg_we_hi, bus.out_illegal};
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      exp_cnt = 0;
    end else if (bus.flush) begin
      q.delete();
    end else begin
      if (bus.out_valid && bus.out_ready) begin
        if (q.size() == 0)
          chk("sb_underflow", 1, 0);
        else
          chk("bundle", 64'(got_bun()),
              64'(q.pop_front()));
      end
      if (bus.in_valid && bus.in_ready) begin
        q.push_back(model(bus.in_instr));
        if (model(bus.in_instr).illegal && exp_cnt < 255)
          exp_cnt++;
      end
    end
  end

  task automatic send(input logic [31:0] ins,
                      output int stalls);
    stalls = 0;
    bus.in_valid = 1'b1;
    bus.in_instr = ins;
    forever begin
      if (rnd) bus.out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (bus.in_ready) break;
      stalls++;
      if (stalls > 100) begin
        chk("send_timeout", 1, 0);
        break;
      end
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    bus.in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int st;
    bus.in_valid  = 1'b0;
    bus.in_instr  = '0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_bundle", 64'(got_bun()), 0);
    chk("rst_cnt", bus.illegal_count, 0);
    @(posedge clk);
    #1 rst = 1'b0;

    send(LDI, st);
    chk("ldi_valid", bus.out_valid, 1);
    chk("ldi_rd", bus.out_rd, 2);
    chk("ldi_imm", bus.out_imm, 16'h1234);
    chk("ldi_use_imm", bus.out_use_imm, 1);
    chk("ldi_we", bus.out_reg_we, 1);
    idle(2);

    bus.out_ready = 1'b0;
    send(ADD, st);
    repeat (3) begin
      @(negedge clk);
      chk("bp_valid", bus.out_valid, 1);
      chk("bp_rd", bus.out_rd, 3);
      chk("bp_in_ready", bus.in_ready, 0);
    end
    @(posedge clk);
    #1 bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_drain", bus.out_valid, 0);

    send(LD5, st);
    send(ADD5, st);
    chk("lu_stall_rs1", st, 2);
    idle(3);
    send(LD5, st);
    send(ADD, st);
    chk("lu_nostall", st, 0);
    idle(3);
    send(LD5, st);
    send(ADDB, st);
    chk("lu_stall_rs2", st, 2);
    idle(3);

    send(MUL, st);
    chk("mul_we", bus.out_reg_we, 1);
    chk("mul_we_hi", bus.out_reg_we_hi, 1);
    chk("mul_rd", bus.out_rd, 4);
    chk("mul_rd_hi", bus.out_rd_hi, 7);
    send(STR, st);
    chk("st_wr", bus.out_mem_wr, 1);
    chk("st_addr", bus.out_mem_addr, 8'h5A);
    chk("st_we", bus.out_reg_we, 0);
    idle(2);

    rnd = 1'b1;
    for (int k = 0; k < 60; k++) begin
      logic [5:0] op;
      op = 6'($urandom_range(0, 20));
      send({op, 26'($urandom)}, st);
    end
    rnd = 1'b0;
    bus.out_ready = 1'b1;
    idle(4);
    chk("cnt_rand", bus.illegal_count, exp_cnt);

    for (int k = 0; k < 300; k++)
      send({6'h3F, 26'($urandom)}, st);
    idle(3);
    chk("cnt_sat", bus.illegal_count, 255);
    chk("sb_drain1", q.size(), 0);

    bus.out_ready = 1'b0;
    send(LDI, st);
    bus.in_valid = 1'b1;
    bus.in_instr = ADD;
    bus.flush = 1'b1;
    @(negedge clk);
    chk("flush_in_ready", bus.in_ready, 0);
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
    bus.in_valid = 1'b0;
    chk("flush_valid", bus.out_valid, 0);
    chk("flush_cnt", bus.illegal_count, 255);
    bus.out_ready = 1'b1;
    idle(2);
    chk("flush_stays", bus.out_valid, 0);

    bus.out_ready = 1'b0;
    send(MOV, st);
    chk("pre_rst_valid", bus.out_valid, 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", bus.out_valid, 0);
    chk("arst_bundle", 64'(got_bun()), 0);
    chk("arst_cnt", bus.illegal_count, 0);
    chk("arst_in_ready", bus.in_ready, 0);
    @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    bus.out_ready = 1'b1;
    send(LDI, st);
    chk("post_rst_valid", bus.out_valid, 1);
    idle(3);
    chk("sb_empty", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
